reg_wr_arb: RTL and testbench

Write-port arbiter for the 16-bit register bank. Up to four requesters (decode, memory writeback, interrupt save, debug) compete for the bank's single write port (write enable, 3-bit address, 16-bit data, as consumed by the bank's write-enabled 16-bit registers). The block selects one winner per cycle, drives the write port from a registered stage, and returns a one-cycle acknowledge to the winner.

---
 rtl/reg_arb_pkg.sv | 12 +
 rtl/reg_wr_arb_rr_pick.sv | 43 ++++
 rtl/reg_wr_arb.sv | 74 +++++++
 tb/tb_reg_wr_arb.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared constants for the register-bank write-port arbiter.
package reg_arb_pkg;
  localparam int NREQ = 4;
  localparam int AW   = 3;
  localparam int DW   = 16;
  localparam int PTRW = $clog2(NREQ);

  localparam int REQ_DEC = 0;
  localparam int REQ_MEM = 1;
  localparam int REQ_INT = 2;
  localparam int REQ_DBG = 3;
endpackage

// File: rtl/reg_wr_arb_rr_pick.sv
// Rotating-priority picker (rr_pick) and the async-reset dff cell used for
// the arbiter's registered outputs.
module rr_pick
  import reg_arb_pkg::*;
(
  input  logic [NREQ-1:0] elig_i,
  input  logic [PTRW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PTRW-1:0] idx_o,
  output logic            any_o
);
  logic [PTRW-1:0] cand;

  // Scan from ptr upward (mod NREQ); the first eligible requester wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr_i + PTRW'(k);
      if (!any_o && elig_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end
endmodule

module reg_arb_dff #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_o <= '0;
    else         q_o <= d_i;
  end
endmodule

// File: rtl/reg_wr_arb.sv
// Write-port arbiter for the 16-bit register bank: one grant per cycle, registered
// write port and one-cycle ack. Define REG_WR_ARB_RR_EN for round-robin, else fixed priority.
module reg_wr_arb
  import reg_arb_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*AW-1:0] req_addr_i,
  input  logic [NREQ*DW-1:0] req_data_i,
  input  logic               wr_stall_i,
  output logic [NREQ-1:0]    ack_o,
  output logic               wr_en_o,
  output logic [AW-1:0]      wr_addr_o,
  output logic [DW-1:0]      wr_data_o,
  output logic               busy_o
);
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt;
  logic [PTRW-1:0] idx;
  logic            any;
  logic [PTRW-1:0] ptr_q;

  logic [NREQ-1:0] ack_q;
  logic            wr_en_q;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;

  // The ack mask keeps a requester still holding req in its ack cycle from a second grant.
  assign elig = req_i & ~ack_q & {NREQ{~wr_stall_i}};

  rr_pick u_pick (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt),
    .idx_o  (idx),
    .any_o  (any)
  );

`ifdef REG_WR_ARB_RR_EN
  logic [PTRW-1:0] ptr_d;
  assign ptr_d = any ? idx + PTRW'(1) : ptr_q;

  reg_arb_dff #(.W(PTRW)) u_ptr (
    .clk_i (clk_i), .rst_ni (rst_ni), .d_i (ptr_d), .q_o (ptr_q)
  );
`else
  assign ptr_q = '0;
`endif

  assign wr_addr_d = any ? req_addr_i[idx*AW +: AW] : wr_addr_q;
  assign wr_data_d = any ? req_data_i[idx*DW +: DW] : wr_data_q;

  reg_arb_dff #(.W(1)) u_wr_en (
    .clk_i (clk_i), .rst_ni (rst_ni), .d_i (any), .q_o (wr_en_q)
  );
  reg_arb_dff #(.W(NREQ)) u_ack (
    .clk_i (clk_i), .rst_ni (rst_ni), .d_i (gnt), .q_o (ack_q)
  );
  reg_arb_dff #(.W(AW)) u_wr_addr (
    .clk_i (clk_i), .rst_ni (rst_ni), .d_i (wr_addr_d), .q_o (wr_addr_q)
  );
  reg_arb_dff #(.W(DW)) u_wr_data (
    .clk_i (clk_i), .rst_ni (rst_ni), .d_i (wr_data_d), .q_o (wr_data_q)
  );

  assign ack_o     = ack_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

  // Forced low in reset so requests held through reset do not show as busy.
  assign busy_o = rst_ni & ((|(req_i & ~ack_q)) | wr_en_q);
endmodule

// File: tb/tb_reg_wr_arb.sv
// Scoreboard bench for reg_wr_arb: stimulus queues expected writes, a negedge
// monitor pops and compares whenever the write port is enabled.
module tb_reg_wr_arb;
  import reg_arb_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               wr_stall;
  logic [NREQ-1:0]    ack;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic               busy;

  logic [AW-1:0] a [NREQ];
  logic [DW-1:0] d [NREQ];

  int n_cmp  = 0;
  int n_fail = 0;
  logic [NREQ+AW+DW-1:0] exp_q [$];

  assign req_addr = {a[3], a[2], a[1], a[0]};
  assign req_data = {d[3], d[2], d[1], d[0]};

  always #5 clk = ~clk;

  reg_wr_arb dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .req_addr_i (req_addr),
    .req_data_i (req_data),
    .wr_stall_i (wr_stall),
    .ack_o      (ack),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .busy_o     (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input int i);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    exp_q.push_back({oh, a[i], d[i]});
  endtask

  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: got ack=%b addr=%0d data=%h, expected no write", ack, wr_addr, wr_data);
      end else begin
        logic [NREQ+AW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({ack, wr_addr, wr_data} !== e) begin
          n_fail++;
          $display("FAIL write: got ack=%b addr=%0d data=%h, expected ack=%b addr=%0d data=%h",
                   ack, wr_addr, wr_data, e[NREQ+AW+DW-1 -: NREQ], e[AW+DW-1 -: AW], e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      a[i] = AW'(i + 1);
      d[i] = 16'hA000 + DW'(i);
    end
    rst_n    = 1'b0;
    req      = 4'b1111;
    wr_stall = 1'b0;

    // Reset held with all requests asserted
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_addr", 32'(wr_addr), 32'd0);
      chk("rst_data", 32'(wr_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    rst_n = 1'b1;
    exp_wr(REQ_DEC);
    step();
    req = 4'b0000;
    step();

    // Single requester; req still high through the ack cycle
    a[2] = 3'd5;
    d[2] = 16'hBEEF;
    req  = 4'b0100;
    exp_wr(REQ_INT);
    step();
    chk("single_busy", 32'(busy), 32'd1);
    step();
    chk("single_no_regrant", 32'(wr_en), 32'd0);
    chk("single_ack_clear", 32'(ack), 32'd0);
    req = 4'b0000;
    step();

    // Async reset while a write is on the port
    req = 4'b0010;
    exp_wr(REQ_MEM);
    step();
    step();
    req = 4'b0000;
    step();
    req = 4'b0010;
    step();
    chk("pre_reset_wr_en", 32'(wr_en), 32'd1);
    #2;
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    chk("async_rst_wr_en", 32'(wr_en), 32'd0);
    chk("async_rst_ack", 32'(ack), 32'd0);
    step();
    rst_n = 1'b1;
    step();

`ifdef REG_WR_ARB_RR_EN
    // Round-robin from ptr=0 after reset: 0,1,2,3,0,1,2,3
    req = 4'b1111;
    for (int k = 0; k < 8; k++) exp_wr(k % NREQ);
    for (int k = 0; k < 8; k++) step();
    req = 4'b0000;
    step();
`else
    // Fixed priority with mask: 1,3,1,3
    req = 4'b1010;
    exp_wr(REQ_MEM);
    exp_wr(REQ_DBG);
    exp_wr(REQ_MEM);
    exp_wr(REQ_DBG);
    for (int k = 0; k < 4; k++) step();
    req = 4'b0000;
    step();
`endif
    chk("no_write_idle", 32'(wr_en), 32'd0);

    // Stall blocks grants for three cycles
    req      = 4'b0011;
    wr_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall_ack", 32'(ack), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    wr_stall = 1'b0;
    exp_wr(REQ_DEC);
    exp_wr(REQ_MEM);
    step();
    step();
    req = 4'b0010;
    step();
    req = 4'b0000;
    step();
    step();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
